seq_det: RTL and testbench
==========================

# seq_det

Mealy-type serial sequence detector that watches a 1-bit input stream, one bit per clock, and flags each occurrence of the pattern 1011. Detection is non-overlapping: after a match, the search restarts from scratch. The detector is a self-contained leaf block. Its pulse output drives event counters or control logic downstream.

## Interface
- Parameters: none. The pattern 1011 is fixed.
- `clk_i`  input  1  single clock; all state updates on its rising edge.
- `rst_i`  input  1  reset, synchronous and active-high.
- `d_i`  input  1  serial data bit, sampled on each rising edge of `clk_i`.
- `sd_o`  output  1  sequence-detected flag. It is combinational (Mealy) and high while the final `1` of a 1011 match is present on `d_i`.
- Port order for positional instantiation: `clk_i`, `rst_i`, `d_i`, `sd_o`.

## Operation
- There are four states:
  - `S_IDLE`: no prefix matched.
  - `S_1`: seen "1".
  - `S_10`: seen "10".
  - `S_101`: seen "101".
- Next-state transitions, given as (`d_i` = 0 / `d_i` = 1):
  - `S_IDLE`: → `S_IDLE` / → `S_1`
  - `S_1`: → `S_10` / → `S_1`
  - `S_10`: → `S_IDLE` / → `S_101`
  - `S_101`: → `S_10` / → `S_IDLE`
- The `S_101` transition on 1 is the detection. It returns to `S_IDLE` because matching is non-overlapping, so no suffix of a match is reused.
- `S_101` on 0 goes to `S_10` because the suffix "10" of "1010" is a valid prefix.
- `sd_o` = (state == `S_101`) && `d_i` && !`rst_i`.
- Every completed, non-overlapping 1011 produces exactly one high interval on `sd_o`, one clock period long. Two back-to-back matches are separated by at least 3 low cycles, so the bench can count matches on the rising edges of `sd_o`.
- `d_i` is treated as a 0/1 value. The behaviour when `d_i` is X or Z is undefined.

## Timing
- State register: updates on the rising edge of `clk_i` only.
- Reset:
  - If `rst_i` = 1 at a rising edge, the state becomes `S_IDLE`.
  - While `rst_i` is high, `sd_o` = 0 regardless of state or `d_i`.
  - The reset value of `sd_o` is 0.
  - A reset asserted mid-pattern discards the partial match. Bits presented during reset cycles are not consumed.
- Latency:
  - `sd_o` rises combinationally, within the same cycle that the fourth bit (`1`) is held on `d_i`.
  - The edge that consumes that bit moves the state to `S_IDLE`, which drops `sd_o`.
  - Latency from the last pattern bit to the flag is 0 cycles.
- Input setup: `d_i` may change just after a rising edge. It must be stable before the next rising edge.
- The output may glitch with `d_i` while the state is `S_101`. Downstream logic must sample `sd_o` synchronously, or use its rising edge only as an event.
- Simultaneous reset and final bit: reset wins, and no detection is reported.

## Structure
- Shared package `seq_det_pkg`:
  - state enum `state_t` (`S_IDLE`, `S_1`, `S_10`, `S_101`), 2-bit encoding;
  - constant `SEQ_PATTERN` = 4'b1011 for documentation and bench reference models.
- Single module with two parts:
  - a registered `state` with synchronous reset;
  - one combinational block that computes `next_state` and `sd_o`.
- No sub-module is needed.

## Test plan
- Reset, then stream 1,0,1,1 → `sd_o` = 1 only during the 4th bit; state is `S_IDLE` afterwards.
- Stream 1,0,1,1,0,1,1 → exactly one pulse, at bit 4. There is no pulse at bit 7, which proves non-overlap.
- Stream 1,1,0,1,0,1,1 → exactly one pulse, at bit 7. This exercises the `S_1` self-loop and the `S_101` on 0 → `S_10` transition.
- Stream 1,0,1,1,1,0,1,1 → pulses at bits 4 and 8.
- Stream 1,0,1, then assert `rst_i` for 1 cycle while `d_i` = 1, then 1 → no pulse. `sd_o` stays 0 throughout reset.
- 130 pseudo-random bits at 1 bit per 10-time-unit clock, after 2 reset cycles → the count of `sd_o` rising edges equals a non-overlapping 1011 reference-model count.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011 serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_101  = 2'd3
  } state_t;

  localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_det.sv
// Mealy detector for non-overlapping occurrences of 1011 on a serial input.
module seq_det
  import seq_det_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sd_o
);

  state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sd_o    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = d_i ? S_1 : S_IDLE;
      S_1:    state_d = d_i ? S_1 : S_10;
      S_10:   state_d = d_i ? S_101 : S_IDLE;
      S_101: begin
        // A match restarts the search; "1010" keeps its "10" suffix.
        state_d = d_i ? S_IDLE : S_10;
        sd_o    = d_i && !rst_i;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_det.sv
// Self-checking bench for seq_det: directed vector table plus a random stream.
module tb_seq_det;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'b0;
  logic sd;

  int checks = 0;
  int errors = 0;

  seq_det dut (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (d),
    .sd_o (sd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic d;
    logic exp_sd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic b, input logic e);
    vec_t v;
    v.rst    = r;
    v.d      = b;
    v.exp_sd = e;
    vecs.push_back(v);
  endfunction

  // Drive inputs just after a rising edge, sample on the falling edge.
  task automatic step(input logic r, input logic b, output logic s);
    @(posedge clk);
    #1;
    rst = r;
    d   = b;
    @(negedge clk);
    s = sd;
  endtask

  initial begin
    logic       s;
    logic       prev_s;
    logic [3:0] hist;
    int         len;
    int         exp_cnt;
    int         rise_cnt;
    logic       b;
    logic       e;

    // Reset cycles, including d=1 which must not raise the flag.
    add(1, 0, 0); add(1, 1, 0);
    // 1011: pulse on the fourth bit only.
    add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    // 1011011: non-overlap, no pulse at bit 7.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    add(0, 0, 0); add(0, 1, 0); add(0, 1, 0);
    // 1101011: S_1 self-loop and S_101 -0-> S_10, pulse at bit 7.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 1, 0); add(0, 0, 0); add(0, 1, 0);
    add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    // 10111011: pulses at bits 4 and 8.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);
    // 101, reset with d=1 while in S_101, then 1: reset wins, partial match dropped.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 1, 0);
    add(1, 1, 0);
    add(0, 1, 0);
    // Continue with 011 from S_1 to show the state was cleared to idle.
    add(0, 0, 0); add(0, 1, 0); add(0, 1, 1);

    // Hold reset across the first edge before the table starts.
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].d, s);
      checks++;
      if (s !== vecs[i].exp_sd) begin
        errors++;
        $display("FAIL vec[%0d] rst=%0b d=%0b sd_o got %0b want %0b",
                 i, vecs[i].rst, vecs[i].d, s, vecs[i].exp_sd);
      end
    end

    // Random stream against a sliding-window non-overlapping reference.
    step(1, 0, s);
    step(1, 1, s);
    hist     = 4'b0000;
    len      = 0;
    exp_cnt  = 0;
    rise_cnt = 0;
    prev_s   = 1'b0;
    for (int i = 0; i < 130; i++) begin
      b    = 1'($urandom_range(0, 1));
      hist = {hist[2:0], b};
      len++;
      e    = (len >= 4) && (hist == SEQ_PATTERN);
      if (e) begin
        exp_cnt++;
        len = 0;
      end
      step(0, b, s);
      checks++;
      if (s !== e) begin
        errors++;
        $display("FAIL rand bit %0d d=%0b sd_o got %0b want %0b", i, b, s, e);
      end
      if (s === 1'b1 && prev_s !== 1'b1) rise_cnt++;
      prev_s = s;
    end
    checks++;
    if (rise_cnt != exp_cnt) begin
      errors++;
      $display("FAIL rand match count got %0d want %0d", rise_cnt, exp_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
